// File: rtl/mem_prefetch_reader.sv
// Burst read initiator: credit-limited reads on the shared mem_* port, ID-matched returns into a FIFO, valid/ready word stream out.
// Optional MEM_PREFETCH_STATS_EN adds stat_stall, a saturating count of waitrequest-stalled read cycles.
module mem_prefetch_reader #(
  parameter int unsigned ID         = 1,
  parameter int unsigned BURST_BITS = 2,
  parameter int unsigned FIFO_BITS  = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [29:0] base,
  input  logic [21:0] nbursts,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef MEM_PREFETCH_STATS_EN
  ,
  output logic [31:0] stat_stall
`endif
);

  localparam int unsigned BURST_LEN = 1 << BURST_BITS;
  localparam int unsigned DEPTH     = 1 << FIFO_BITS;
  localparam int unsigned CW        = FIFO_BITS + 2;
  localparam logic [FIFO_BITS:0] PTR_ONE = (FIFO_BITS + 1)'(1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t             state;
  logic [21:0]        left;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      inflight_next;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      fifo_count_next;
  logic               credit_ok;

  logic [FIFO_BITS:0] wptr;
  logic [FIFO_BITS:0] rptr;
  logic [FIFO_BITS:0] mem_count;
  logic [31:0]        store [DEPTH];

  logic               id_match;
  logic               push;
  logic               pop;
  logic               load;
  logic               accept;
  logic               start_ok;

  assign mem_id            = 2'(ID);
  assign mem_write         = 1'b0;
  assign mem_writedata     = '0;
  assign mem_writedatamask = '0;

  // Occupancy includes the registered output word, so credit covers it too.
  always_comb begin
    id_match        = (mem_readdataid == 2'(ID));
    push            = id_match && (inflight != '0);
    pop             = out_valid && out_ready;
    accept          = mem_read && !mem_waitrequest;
    start_ok        = start && (state == IDLE);
    mem_count       = wptr - rptr;
    load            = (mem_count != '0) && (!out_valid || out_ready);
    fifo_count      = CW'(mem_count) + CW'(out_valid);
    fifo_count_next = fifo_count + CW'(push) - CW'(pop);
    inflight_next   = inflight + (accept ? CW'(BURST_LEN) : CW'(0)) - CW'(push);
    credit_ok       = (fifo_count_next + inflight_next) <= CW'(DEPTH - BURST_LEN);
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      left        <= '0;
      inflight    <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= inflight_next;
      if (id_match && (inflight == '0))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start_ok) begin
            if (nbursts == '0) begin
              done <= 1'b1;
            end else begin
              state       <= REQ;
              busy        <= 1'b1;
              mem_address <= base;
              left        <= nbursts;
              mem_read    <= credit_ok;
            end
          end
        end
        REQ: begin
          // A pending request is held until accepted; credit only grows meanwhile.
          if (accept) begin
            mem_address <= mem_address + 30'(BURST_LEN);
            left        <= left - 22'd1;
            if (left == 22'd1) begin
              state    <= DRAIN;
              mem_read <= 1'b0;
            end else begin
              mem_read <= credit_ok;
            end
          end else if (!mem_read) begin
            mem_read <= credit_ok;
          end
        end
        DRAIN: begin
          if (inflight_next == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      store[wptr[FIFO_BITS-1:0]] <= mem_readdata;
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push)
        wptr <= wptr + PTR_ONE;
      if (load) begin
        out_data  <= store[rptr[FIFO_BITS-1:0]];
        out_valid <= 1'b1;
        rptr      <= rptr + PTR_ONE;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MEM_PREFETCH_STATS_EN
  always_ff @(posedge clock) begin
    if (!rst || start_ok)
      stat_stall <= '0;
    else if (mem_read && mem_waitrequest && (stat_stall != '1))
      stat_stall <= stat_stall + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_prefetch_reader.sv
// Bench for mem_prefetch_reader: controller model, word-level reference model with per-cycle compare, directed scenarios.
module tb_mem_prefetch_reader;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [29:0] base = '0;
  logic [21:0] nbursts = '0;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        mem_waitrequest = 1'b0;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata = '0;
  logic [1:0]  mem_readdataid = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef MEM_PREFETCH_STATS_EN
  logic [31:0] stat_stall;
  logic [31:0] stat_m = '0;
`endif

  always #5 clock = ~clock;

  mem_prefetch_reader #(.ID(1), .BURST_BITS(2), .FIFO_BITS(4)) dut (
    .clock(clock), .rst(rst), .start(start), .base(base), .nbursts(nbursts),
    .busy(busy), .done(done), .overrun(overrun),
    .mem_waitrequest(mem_waitrequest), .mem_id(mem_id), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
    .mem_readdataid(mem_readdataid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MEM_PREFETCH_STATS_EN
    , .stat_stall(stat_stall)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: words requested but not returned, words received but not popped.
  int unsigned cyc = 0;
  logic        busy_m = 1'b0;
  logic        done_m = 1'b0;
  logic        overrun_m = 1'b0;
  int unsigned outstanding_m = 0;
  int unsigned words_left_m = 0;
  int unsigned bursts_left_m = 0;
  logic [29:0] exp_addr = '0;
  logic [31:0] expq[$];
  int unsigned recvq[$];
  logic [29:0] acc_addr[$];
  logic [31:0] got[$];
  int unsigned issued = 0;
  int unsigned delivered = 0;
  int unsigned done_cnt = 0;

  typedef struct { logic [31:0] data; int unsigned due; } ret_t;
  ret_t        pend[$];
  int unsigned wait_cfg = 0;
  int unsigned stall_left = 0;
  bit          foreign_en = 1'b0;

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return {2'b11, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    logic busy_pre;
    logic exp_valid;
    forever begin
      @(posedge clock);
      cyc++;
      busy_pre = busy_m;
      if (!rst) begin
        busy_m = 1'b0; done_m = 1'b0; overrun_m = 1'b0;
        outstanding_m = 0; words_left_m = 0; bursts_left_m = 0;
        expq.delete(); recvq.delete();
        stall_left = wait_cfg;
`ifdef MEM_PREFETCH_STATS_EN
        stat_m = '0;
`endif
      end else begin
        done_m = 1'b0;
`ifdef MEM_PREFETCH_STATS_EN
        if (start && !busy_pre) stat_m = '0;
        else if (mem_read && mem_waitrequest && stat_m != 32'hFFFF_FFFF) stat_m++;
`endif
        if (out_valid && out_ready) begin
          got.push_back(out_data);
          delivered++;
          if (expq.size() != 0) void'(expq.pop_front());
          if (recvq.size() != 0) void'(recvq.pop_front());
        end
        if (mem_readdataid == 2'd1) begin
          if (outstanding_m == 0) overrun_m = 1'b1;
          else begin
            outstanding_m--;
            recvq.push_back(cyc);
            words_left_m--;
            if (words_left_m == 0) begin busy_m = 1'b0; done_m = 1'b1; end
          end
        end
        if (mem_read && !mem_waitrequest) begin
          acc_addr.push_back(mem_address);
          issued++;
          for (int i = 0; i < 4; i++) begin
            expq.push_back(word_of(exp_addr + 30'(i)));
            pend.push_back('{word_of(mem_address + 30'(i)), cyc + 3 + i});
          end
          exp_addr = exp_addr + 30'd4;
          outstanding_m += 4;
          if (bursts_left_m != 0) bursts_left_m--;
          stall_left = wait_cfg;
        end
        if (start && !busy_pre) begin
          if (nbursts == '0) done_m = 1'b1;
          else begin
            busy_m = 1'b1;
            words_left_m = 4 * int'(nbursts);
            bursts_left_m = int'(nbursts);
            exp_addr = base;
          end
        end
      end

      @(negedge clock);
      if (done) done_cnt++;
      check("busy", busy, busy_m);
      check("done", done, done_m);
      check("overrun", overrun, overrun_m);
      exp_valid = (recvq.size() != 0) && (recvq[0] < cyc);
      check("out_valid", out_valid, exp_valid);
      if (out_valid && expq.size() != 0) check("out_data", out_data, expq[0]);
      if (mem_read) begin
        check("mem_address", mem_address, exp_addr);
        check("credit", (outstanding_m + recvq.size() + 4) <= 16, 1);
        check("read_needed", bursts_left_m != 0, 1);
      end
`ifdef MEM_PREFETCH_STATS_EN
      check("stat_stall", stat_stall, stat_m);
`endif

      mem_waitrequest = 1'b0;
      if (mem_read && stall_left > 0) begin
        mem_waitrequest = 1'b1;
        stall_left--;
      end
      mem_readdataid = 2'd0;
      mem_readdata = '0;
      if (foreign_en && (cyc % 3 == 0)) begin
        mem_readdataid = 2'd2;
        mem_readdata = 32'hDEAD_0000 ^ cyc;
      end else if (pend.size() != 0 && pend[0].due <= cyc) begin
        mem_readdataid = 2'd1;
        mem_readdata = pend[0].data;
        void'(pend.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_start(input logic [29:0] b, input logic [21:0] n);
    base = b; nbursts = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned maxc, input string name);
    int unsigned n = 0;
    while ((busy_m || expq.size() != 0 || pend.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    check(name, n < maxc, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int unsigned i0, g0, d0, dc0, n;
    rst = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_address", mem_address, 30'h0);
    check("mem_id", mem_id, 2'd1);
    check("mem_write", mem_write, 0);
    check("mem_writedata", mem_writedata, 32'h0);
    check("mem_writedatamask", mem_writedatamask, 4'h0);
    rst = 1'b1;
    tick();

    // Basic transfer with 2 waitrequest cycles per request, plus an ignored start.
    out_ready = 1'b1; wait_cfg = 2; stall_left = 2;
    i0 = issued; g0 = got.size(); d0 = delivered; dc0 = done_cnt;
    do_start(30'h100, 22'd2);
    check("basic_busy_after_start", busy, 1);
    check("basic_read_after_start", mem_read, 1);
    tick();
    do_start(30'h200, 22'd5);
    wait_idle(200, "basic_timeout");
    tick();
    check("basic_bursts", issued - i0, 2);
    check("basic_addr0", acc_addr[i0], 30'h100);
    check("basic_addr1", acc_addr[i0 + 1], 30'h104);
    check("basic_words", delivered - d0, 8);
    check("basic_first_word", got[g0], 32'hC000_0100);
    check("basic_last_word", got[g0 + 7], 32'hC000_0107);
    check("basic_done_pulses", done_cnt - dc0, 1);

    // Backpressure: FIFO fills at 16 words and issue stops.
    out_ready = 1'b0; wait_cfg = 0; stall_left = 0;
    i0 = issued; g0 = got.size(); d0 = delivered;
    do_start(30'h2000, 22'd8);
    repeat (60) tick();
    check("bp_bursts_held", issued - i0, 4);
    check("bp_read_low", mem_read, 0);
    check("bp_valid", out_valid, 1);
    check("bp_no_overrun", overrun, 0);
    out_ready = 1'b1;
    wait_idle(400, "bp_timeout");
    tick();
    check("bp_bursts_total", issued - i0, 8);
    check("bp_words", delivered - d0, 32);
    check("bp_last_word", got[g0 + 31], 32'hC000_201F);

    // Zero length: done next cycle, no reads.
    i0 = issued;
    do_start(30'h55, 22'd0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    tick();
    check("zero_done_clear", done, 0);
    repeat (5) tick();
    check("zero_no_reads", issued - i0, 0);

    // Address wrap with interleaved foreign-ID words.
    foreign_en = 1'b1;
    i0 = issued; g0 = got.size(); d0 = delivered;
    do_start(30'h3FFF_FFFC, 22'd2);
    wait_idle(300, "wrap_timeout");
    foreign_en = 1'b0;
    tick();
    check("wrap_addr0", acc_addr[i0], 30'h3FFF_FFFC);
    check("wrap_addr1", acc_addr[i0 + 1], 30'h0);
    check("wrap_words", delivered - d0, 8);
    check("wrap_word3", got[g0 + 3], 32'hFFFF_FFFF);
    check("wrap_word4", got[g0 + 4], 32'hC000_0000);

    // Reset mid-transfer; late returns of the aborted transfer raise overrun.
    i0 = issued;
    do_start(30'h400, 22'd4);
    n = 0;
    while (issued - i0 < 2 && n < 40) begin tick(); n++; end
    check("rst_mid_reach", n < 40, 1);
    rst = 1'b0;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_read", mem_read, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_address", mem_address, 30'h0);
    rst = 1'b1;
    n = 0;
    while (pend.size() != 0 && n < 60) begin tick(); n++; end
    check("stray_drain", n < 60, 1);
    repeat (3) tick();
    check("stray_overrun", overrun, 1);
    check("stray_fifo_empty", out_valid, 0);
    check("stray_idle", busy, 0);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

`ifdef MEM_PREFETCH_STATS_EN
    // Five stalled cycles on the first request, then cleared by a new start.
    wait_cfg = 0; stall_left = 5;
    do_start(30'h800, 22'd1);
    wait_idle(100, "stats_timeout");
    check("stats_count", stat_stall, 32'd5);
    stall_left = 0;
    do_start(30'h900, 22'd1);
    check("stats_clear", stat_stall, 32'd0);
    wait_idle(100, "stats2_timeout");
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_prefetch_reader.md
# mem_prefetch_reader

Read-side initiator for the shared `mem_*` port of the SRAM controller. It takes a base word address and a burst count, issues burst reads tagged with its own ID, and collects the returned words by matching `mem_readdataid`. The words go through an internal FIFO and leave as a valid/ready word stream. It sits between the SRAM controller and stream consumers such as the framebuffer scanout and the block-copy engine.

## Interface
- `ID`, 1: 2-bit request tag driven on `mem_id`. Must be nonzero because ID 0 means "no data".
- `BURST_BITS`, 2: log2 of the burst length. Must match the controller, so BURST_LEN = 4 words.
- `FIFO_BITS`, 4: log2 of the FIFO depth, so DEPTH = 16 words. Requires DEPTH ≥ 2·BURST_LEN.

Ports:
- `clock` in 1: sole clock. All logic is on posedge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle command strobe. Ignored while `busy`.
- `base` in 30: word address of the first burst, sampled on `start`.
- `nbursts` in 22: number of bursts to read, sampled on `start`.
- `busy` out 1: high from the cycle after an accepted `start` until the last word is received.
- `done` out 1: one-cycle pulse when the last word is received.
- `overrun` out 1: sticky error flag, cleared only by reset.
- `mem_waitrequest` in 1: controller stall.
- `mem_id` out 2: constant `ID`.
- `mem_address` out 30: burst start address.
- `mem_read` out 1: read request.
- `mem_write` out 1: tied 0.
- `mem_writedata` out 32: tied 0.
- `mem_writedatamask` out 4: tied 0.
- `mem_readdata` in 32: returned word.
- `mem_readdataid` in 2: tag of `mem_readdata`. 0 means no data.
- `out_data` out 32: stream word.
- `out_valid` out 1: stream word present.
- `out_ready` in 1: consumer accepts the word.

## Operation
- State machine:
  - IDLE → REQ on an accepted `start` with `nbursts` ≠ 0. `addr` ← `base`, `left` ← `nbursts`.
  - `start` with `nbursts` = 0: `done` pulses the next cycle, no reads are issued, and the block stays in IDLE.
  - REQ: assert `mem_read` only when credit = DEPTH − fifo_count − inflight is ≥ BURST_LEN.
  - A read is accepted on any cycle with `mem_read` && !`mem_waitrequest`. On acceptance: `inflight` += BURST_LEN, `addr` += BURST_LEN (modulo 2^30, wraps silently), `left` −= 1. If `left` reaches 0, go to DRAIN.
  - DRAIN → IDLE when `inflight` = 0. Pulse `done` and drop `busy` in that same transition cycle.
- Once `mem_read` is asserted, it and `mem_address` are held stable until accepted. The request is never withdrawn.
- Return path:
  - A word with `mem_readdataid` == `ID` is pushed into the FIFO and decrements `inflight`.
  - Other IDs are ignored.
  - There is no backpressure on returns. Credit accounting guarantees the FIFO never overflows.
  - If a matching word arrives while `inflight` = 0, the word is dropped and `overrun` is set.
- FIFO:
  - Circular buffer, FIFO_BITS+1 pointers.
  - Pop on `out_valid` && `out_ready`.
  - A simultaneous push and pop at full or at empty is legal and leaves the count unchanged.
  - FIFO contents persist after `done` until they are drained.
- Reset values:
  - `busy`, `done`, `overrun`, `mem_read`, `out_valid` = 0.
  - `mem_address` = 0.
  - FIFO empty, `inflight` = 0, state IDLE.
- Reset mid-operation aborts the transfer immediately. Data for the aborted transfer that arrives after reset sets `overrun`. The bench must treat that as expected.

## Timing
- `start` is sampled at edge T. `busy` and the first `mem_read` are visible after edge T+1, provided there is credit.
- A word pushed at edge N (ID match) is presented on `out_valid`/`out_data` after edge N+1. This is a registered FIFO output.
- Sustained throughput is 1 word/cycle on both ports.
- A back-to-back burst issue is possible on the cycle after acceptance if credit allows.
- There is no assumption on read latency or on the number of waitrequest cycles.

## Configuration
- `MEM_PREFETCH_STATS_EN` defined: adds output `stat_stall` [31:0].
  - Counts cycles with `mem_read` && `mem_waitrequest`.
  - Cleared by reset and by an accepted `start`.
  - Saturates at 2^32−1.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Basic transfer:** `base`=0x100, `nbursts`=2, `out_ready`=1, controller model with 2-cycle waitrequest → two reads at 0x100 and 0x104, 8 words in address order, `done` pulses once, `busy` falls in the same cycle.
- **Backpressure:** `nbursts`=8, `out_ready`=0 → at most 4 bursts issued (16 words, FIFO full), `mem_read` stays low, no `overrun`. Raising `out_ready` resumes issue and all 32 words are delivered.
- **Zero length:** `nbursts`=0 → `done` pulses at T+1, `mem_read` is never asserted.
- **Wrap and foreign IDs:** `base`=0x3FFFFFFC, `nbursts`=2 → second address is 0x00000000. Interleaved ID=2 words are ignored and not counted.
- **Reset and stray data:**
  - `rst` low mid-burst → all outputs return to reset values, FIFO empty.
  - A late ID-matched word afterwards → `overrun`=1, FIFO still empty.
  - A `start` while `busy` is ignored.
- **Stats (macro on):** waitrequest forced high for 5 cycles on the first request → `stat_stall`=5. A new `start` clears it to 0.
